// File: rtl/tft_timing_pkg.sv
// Shared timing defaults, pixel/delay-line bundles and colour-bar table
// for the 480x272 TFT video source.
package tft_timing_pkg;

  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_H_SYNC   = 41;
  localparam int DEF_H_BP     = 2;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_V_SYNC   = 10;
  localparam int DEF_V_BP     = 2;

  localparam int H_TOT = DEF_H_ACTIVE + DEF_H_FP
                       + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOT = DEF_V_ACTIVE + DEF_V_FP
                       + DEF_V_SYNC + DEF_V_BP;
  localparam int PIXELS_PER_FRAME = DEF_H_ACTIVE * DEF_V_ACTIVE;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef struct packed {
    logic       hs_n;
    logic       vs_n;
    logic       de;
    logic [9:0] h;
  } dly_t;

  localparam dly_t DLY_IDLE = '{
    hs_n: 1'b1, vs_n: 1'b1, de: 1'b0, h: 10'd0
  };

  localparam logic [23:0] BAR_TBL [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // 60-pixel-wide bars; only meaningful while DE is high
  function automatic rgb24_t bar_rgb(input logic [9:0] h);
    logic [9:0] q;
    q = h / 10'd60;
    return rgb24_t'(BAR_TBL[q[2:0]]);
  endfunction

endpackage

// File: rtl/tft_timing_gen_sync_delay.sv
// Shift register carrying sync/DE/hcnt alongside the BRAM read pipeline.
// o_pre is one stage before the output, aligned with returned BRAM data.
module tft_sync_delay
  import tft_timing_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic CLK,
  input  logic nRESET,
  input  dly_t i_d,
  output dly_t o_q,
  output dly_t o_pre
);

  dly_t r_sr [DEPTH];

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= DLY_IDLE;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q   = r_sr[DEPTH-1];
  assign o_pre = r_sr[DEPTH-2];

endmodule

// File: rtl/tft_timing_gen.sv
// TFT video source: sync/DE generation, BRAM fetch, aligned RGB output.
// Define TFT_TIMING_GEN_TESTPAT_EN to add the TESTPAT colour-bar input.
module tft_timing_gen
  import tft_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int BRAM_LAT = 1,
  parameter int ADDR_W   = $clog2(PIXELS_PER_FRAME)
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              EN,
`ifdef TFT_TIMING_GEN_TESTPAT_EN
  input  logic              TESTPAT,
`endif
  input  logic [23:0]       BRAM_DATA,
  output logic [ADDR_W-1:0] BRAMADDR,
  output logic              BRAM_EN,
  output logic              Hsync,
  output logic              Vsync,
  output logic              DE,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic [9:0]        hcnt,
  output logic [9:0]        vcnt,
  output logic              frame_start
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_B   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_E   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_B   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_E   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_run;
  logic       w_live;
  logic       w_org;
  logic       w_tp;
  logic       w_hs0;
  logic       w_vs0;
  logic       w_de0;
  dly_t       w_d0;
  dly_t       w_q;
  dly_t       w_pre;
  rgb24_t     w_src;
  rgb24_t     r_pix;

`ifdef TFT_TIMING_GEN_TESTPAT_EN
  assign w_tp = TESTPAT;
`else
  assign w_tp = 1'b0;
`endif

  // r_run gives one idle (0,0) cycle after restart so frame_start is clean
  assign w_live = r_run & EN;
  assign w_org  = (r_h == 10'd0) & (r_v == 10'd0);
  assign w_hs0  = w_live & (r_h >= HS_B) & (r_h < HS_E);
  assign w_vs0  = w_live & (r_v >= VS_B) & (r_v < VS_E);
  assign w_de0  = w_live & (r_h < H_ACT) & (r_v < V_ACT);

  always_ff @(posedge CLK) begin
    if (!nRESET || !EN) begin
      r_run <= 1'b0;
      r_h   <= 10'd0;
      r_v   <= 10'd0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (r_h == H_LAST) begin
          r_h <= 10'd0;
          r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      BRAM_EN  <= 1'b0;
      BRAMADDR <= '0;
    end else begin
      BRAM_EN <= w_de0 & ~w_tp;
      if (w_org)
        BRAMADDR <= '0;
      else if (BRAM_EN)
        BRAMADDR <= BRAMADDR + ADDR_W'(1);
    end
  end

  always_comb begin
    w_d0      = DLY_IDLE;
    w_d0.hs_n = ~w_hs0;
    w_d0.vs_n = ~w_vs0;
    w_d0.de   = w_de0;
    w_d0.h    = r_h;
  end

  tft_sync_delay #(
    .DEPTH (BRAM_LAT + 2)
  ) u_dly (
    .CLK    (CLK),
    .nRESET (nRESET),
    .i_d    (w_d0),
    .o_q    (w_q),
    .o_pre  (w_pre)
  );

  always_comb begin
    w_src = rgb24_t'(BRAM_DATA);
    if (w_tp) w_src = bar_rgb(w_pre.h);
  end

  always_ff @(posedge CLK) begin
    if (!nRESET)
      r_pix <= '0;
    else
      r_pix <= w_pre.de ? w_src : '0;
  end

  assign Hsync       = w_q.hs_n;
  assign Vsync       = w_q.vs_n;
  assign DE          = w_q.de;
  assign R           = r_pix.r;
  assign G           = r_pix.g;
  assign B           = r_pix.b;
  assign hcnt        = r_h;
  assign vcnt        = r_v;
  assign frame_start = r_run & w_org;

endmodule

// File: doc/tft_timing_gen.md
Name: tft_timing_gen

Overview:
- Video source side of the TFT-LCD pixel interface. Generates Hsync, Vsync and DE plus hcnt/vcnt for a 480x272 panel.
- Issues sequential BRAM read addresses during the active area and registers the returned 24-bit pixel onto R/G/B.
- Sync and DE are delayed so they stay cycle-aligned with the pixel data.
- Drives the timing/pixel inputs that the LCD controller and tracker consume.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 41, Hsync pulse width (clocks)
- H_BP, 2, horizontal back porch (clocks)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, Vsync pulse width (lines)
- V_BP, 2, vertical back porch (lines)
- BRAM_LAT, 1, BRAM read latency (clocks, 1..3)
- ADDR_W, 17, BRAM address width

Ports:
- CLK  in  1  pixel clock (TCLK domain)
- nRESET  in  1  synchronous, active-low reset
- EN  in  1  run enable; 0 = hold timing in restart state
- BRAM_DATA  in  24  pixel {R[23:16],G[15:8],B[7:0]}, valid BRAM_LAT clocks after BRAM_EN
- BRAMADDR  out  ADDR_W  BRAM read address
- BRAM_EN  out  1  BRAM read strobe
- Hsync  out  1  active-low horizontal sync, pipeline-aligned
- Vsync  out  1  active-low vertical sync, pipeline-aligned
- DE  out  1  data enable, pipeline-aligned
- R, G, B  out  8 each  pixel data, 0 outside DE
- hcnt  out  10  raw horizontal counter (stage 0)
- vcnt  out  10  raw vertical counter (stage 0)
- frame_start  out  1  one-clock pulse at stage 0 when h=0 and v=0

Behaviour:
- Clock is CLK. Reset is nRESET: synchronous, active-low.
- Reset values: hcnt=0, vcnt=0, BRAMADDR=0, BRAM_EN=0, Hsync=1, Vsync=1, DE=0, R=G=B=0, frame_start=0. The whole delay line is cleared.
- Horizontal counter:
  - hcnt counts 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP = 525. Wraps to 0.
  - Region order: active [0,479], front porch [480,481], sync [482,522], back porch [523,524].
- Vertical counter:
  - vcnt increments when hcnt wraps, counting 0..V_TOT-1 with V_TOT = 286. Wraps to 0.
  - Region order is the same: active [0,271], FP [272,273], sync [274,283], BP [284,285].
- Raw stage-0 signals:
  - hs0 = (hcnt in sync region); vs0 = (vcnt in sync region); de0 = (hcnt<H_ACTIVE && vcnt<V_ACTIVE).
  - Vsync changes only at hcnt=0.
- Address generation, stage 1 (registered from stage 0):
  - BRAM_EN = de0.
  - BRAMADDR increments by 1 after each issued read. It resets to 0 when stage 0 is at h=0, v=0.
  - The last active pixel reads address 130559. No wrap occurs inside a frame.
- Pixel stage:
  - BRAM_DATA is captured into R/G/B at stage BRAM_LAT+2, gated by the delayed DE; otherwise 0.
  - Hsync, Vsync and DE pass through a delay line of depth BRAM_LAT+2 and register alongside R/G/B.
  - Total latency from stage-0 counters to outputs is BRAM_LAT+2 clocks (3 by default).
- EN behaviour:
  - EN=0 acts as a synchronous restart: counters forced to 0 and BRAM_EN=0. The delay line continues shifting idle values (hs=1 inactive, vs=1, de=0), so outputs drain to idle within BRAM_LAT+2 clocks.
  - On the first clock after EN returns to 1, frame_start pulses and a new frame begins at h=0, v=0.
- Reset or EN drop mid-frame: the partial frame is abandoned, with no extra Hsync pulse emitted. The next frame always starts cleanly at address 0.
- Simultaneous end-of-line and end-of-frame: hcnt and vcnt wrap on the same clock, and frame_start asserts on the following stage-0 cycle at (0,0).

Optional Feature:
- Macro: TFT_TIMING_GEN_TESTPAT_EN.
- Defined: adds an input TESTPAT (1 bit). When TESTPAT=1, BRAM_EN is held 0 and R/G/B come from an internal 8-bar pattern:
  - Bar index = delayed hcnt/60.
  - Bars, in order: white, yellow, cyan, green, magenta, red, blue, black. Components are 8'hFF or 8'h00.
  - Timing and latency are identical to the BRAM path.
- Undefined: no TESTPAT port, and pixels always come from BRAM.

Decomposition:
- Package tft_timing_pkg: default timing constants (H_*/V_* values, H_TOT, V_TOT), PIXELS_PER_FRAME = 130560, the rgb24 packed typedef, and the color-bar constant table.
- One natural sub-module: tft_sync_delay, a parameterised shift register of depth BRAM_LAT+2 carrying {hs,vs,de} and the delayed hcnt.

Test Plan:
- Reset release with EN=1:
  - First Hsync falling edge appears at clock 482+3 after reset and lasts 41 clocks.
  - Line period is 525 clocks; Vsync low for exactly 10×525 = 5250 clocks.
- Frame DE/address count: count DE-high clocks per frame = 130560. BRAMADDR sequence runs 0..130559 with no gaps, then returns to 0 at the next frame_start.
- BRAM model returning addr[23:0] with 1-cycle latency:
  - At the first DE-high output clock, {R,G,B} = 24'h000000; at the second, 24'h000001.
  - Output row 1, column 0 = 480 (24'h0001E0).
- Drop EN at hcnt=300, vcnt=100 for 5 clocks, then raise it:
  - Outputs go idle (DE=0, Hsync=Vsync=1) within 3 clocks.
  - frame_start pulses one clock after EN rises; the next BRAMADDR issued is 0.
- Sweep BRAM_LAT=3: DE-to-data alignment still exact, with the first valid pixel 0 at the output 5 clocks after stage-0 (0,0).
- With TFT_TIMING_GEN_TESTPAT_EN defined and TESTPAT=1: BRAM_EN stays 0; output pixel at column 59 = FFFFFF, column 60 = FFFF00, column 479 = 000000.
